// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, baud divider math and parity helper.
// Used by both the receive and transmit ends of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running tick divider with a synchronous restart for phase alignment.
// Emits a one-cycle tick every DIV clocks.
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling UART receiver: mid-bit majority vote, parity/stop checks,
// break detection and a held valid/ready byte output.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_ferr,
    output logic                 rx_perr,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);
    localparam logic          ODD   = (PARITY_ODD != 0);

    uart_state_t state, next;

    logic                 rx_m, rx_s, rx_p;
    logic                 tick, restart, fall;
    logic [TW-1:0]        tcnt;
    logic                 s0, s1, vote, dec, bend;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bidx;
    logic                 pbit, perr_q;
    logic                 done, brk;

    assign fall    = rx_p & ~rx_s;
    assign restart = (state == IDLE) && fall;
    assign dec     = tick && (tcnt == T_DEC);
    assign bend    = tick && (tcnt == T_END);
    assign vote    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign done    = (state == STOP) && dec;
    assign brk     = !vote && (shreg == '0) && !pbit;
    assign busy    = (state != IDLE);

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:      if (fall) next = START;
            START: begin
                if (dec && vote) next = IDLE;
                else if (bend)   next = DATA;
            end
            DATA: begin
                if (bend && bidx == B_END)
                    next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY:    if (bend) next = STOP;
            STOP:      if (dec) next = vote ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_p      <= 1'b1;
            tcnt      <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            shreg     <= '0;
            bidx      <= '0;
            pbit      <= 1'b0;
            perr_q    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
            rx_perr   <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_p      <= rx_s;
            overrun   <= 1'b0;
            break_det <= 1'b0;

            if (state == IDLE)
                tcnt <= '0;
            else if (tick)
                tcnt <= (tcnt == T_END) ? '0 : tcnt + TW'(1);

            if (tick && tcnt == T_S0) s0 <= rx_s;
            if (tick && tcnt == T_S1) s1 <= rx_s;

            if (state == START) begin
                bidx   <= '0;
                pbit   <= 1'b0;
                perr_q <= 1'b0;
            end
            if (state == DATA && dec)
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (state == DATA && bend)
                bidx <= bidx + BW'(1);
            if (state == PARITY && dec) begin
                pbit   <= vote;
                perr_q <= parity_of(8'(shreg), ODD) ^ vote;
            end

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            // A completion alongside an acceptance replaces the byte in place.
            if (done) begin
                if (brk) begin
                    break_det <= 1'b1;
                end else if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_ferr  <= !vote;
                    rx_perr  <= perr_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomised scoreboard bench: dut_a runs 8N1, dut_b runs 8E1.
// Frames are predicted from line-level rules and checked on acceptance.
module tb_uart_rx_os16;

    localparam int CF = 6400000;
    localparam int BD = 100000;
    localparam int OS = 16;
    localparam int BT = 640;

    typedef struct packed {
        logic [7:0] d;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, ferr_a, perr_a, ovr_a, brk_a, busy_a;
    logic       valid_b, ferr_b, perr_b, ovr_b, brk_b, busy_b;

    uart_rx_os16 #(
        .CLK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .rx_ferr(ferr_a), .rx_perr(perr_a), .overrun(ovr_a),
        .break_det(brk_a), .busy(busy_a)
    );

    uart_rx_os16 #(
        .CLK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .rx_ferr(ferr_b), .rx_perr(perr_b), .overrun(ovr_b),
        .break_det(brk_b), .busy(busy_b)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_ovr[2] = '{0, 0};
    int   n_brk[2] = '{0, 0};
    int   e_ovr[2] = '{0, 0};
    int   e_brk[2] = '{0, 0};
    time  rise_a = 0;
    logic pv_a = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    endtask

    // Monitor: counts pulses and scores every accepted byte.
    always @(negedge clk) begin
        if (rst) begin
            if (ovr_a) n_ovr[0]++;
            if (brk_a) n_brk[0]++;
            if (ovr_b) n_ovr[1]++;
            if (brk_b) n_brk[1]++;
            if (valid_a && !pv_a) rise_a = $time;
            pv_a = valid_a;
            if (valid_a && ready_a) begin
                if (qa.size() == 0) begin
                    n_chk++;
                    $display("FAIL a_unexpected: got byte %0h, want none", data_a);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    check("a_data", data_a, e.d);
                    check("a_ferr", ferr_a, e.ferr);
                    check("a_perr", perr_a, e.perr);
                end
            end
            if (valid_b && ready_b) begin
                if (qb.size() == 0) begin
                    n_chk++;
                    $display("FAIL b_unexpected: got byte %0h, want none", data_b);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    check("b_data", data_b, e.d);
                    check("b_ferr", ferr_b, e.ferr);
                    check("b_perr", perr_b, e.perr);
                end
            end
        end else begin
            pv_a = 1'b0;
        end
    end

    task automatic drive(input int w, input logic v);
        if (w == 0) rx_a = v;
        else        rx_b = v;
    endtask

    // Transmit one frame and predict its outcome from the line contents.
    task automatic send(input int w, input logic [7:0] d, input logic pbit,
                        input logic stop, input int bt);
        exp_t e;
        logic par, rdy;
        int   pend;
        par    = (w == 1);
        e.d    = d;
        e.ferr = !stop;
        e.perr = par ? ((^d) ^ pbit) : 1'b0;
        rdy    = (w == 0) ? ready_a : ready_b;
        pend   = (w == 0) ? qa.size() : qb.size();
        if (d == 8'h00 && !(par && pbit) && !stop) e_brk[w]++;
        else if (!rdy && pend > 0)                 e_ovr[w]++;
        else if (w == 0)                           qa.push_back(e);
        else                                       qb.push_back(e);
        drive(w, 1'b0);
        #(bt);
        for (int i = 0; i < 8; i++) begin
            drive(w, d[i]);
            #(bt);
        end
        if (par) begin
            drive(w, pbit);
            #(bt);
        end
        drive(w, stop);
        #(bt);
        drive(w, 1'b1);
    endtask

    task automatic set_ready_a(input logic v);
        @(posedge clk);
        #1 ready_a = v;
    endtask

    initial begin
        time        t0;
        int         cyc;
        logic [7:0] da, db;
        logic       pb, sa, sb;
        int         bta, btb;
        logic [7:0] sk_d [6];
        int         sk_t [6];
        logic [7:0] rst_pat;

        #23;
        check("rst_data_a", data_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_ovr_a", ovr_a, 0);
        check("rst_brk_a", brk_a, 0);
        check("rst_ferr_b", ferr_b, 0);
        check("rst_perr_b", perr_b, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #(2 * BT);

        t0 = $time;
        send(0, 8'hAB, 1'b0, 1'b1, BT);
        #(BT);
        cyc = int'((rise_a - t0) / 10);
        check("basic_latency_in_600_640", (cyc >= 600 && cyc <= 640), 1);
        check("basic_busy_idle", busy_a, 0);

        send(1, 8'h5A, 1'b0, 1'b1, BT);
        #(2 * BT);
        send(1, 8'h5A, 1'b1, 1'b1, BT);
        #(2 * BT);

        t0 = $time;
        drive(0, 1'b0);
        #100;
        check("glitch_busy_high", busy_a, 1);
        #100;
        drive(0, 1'b1);
        for (int i = 0; i < 60 && busy_a; i++) @(negedge clk);
        cyc = int'(($time - t0) / 10);
        check("glitch_busy_low", busy_a, 0);
        check("glitch_by_clk45", (cyc <= 45), 1);
        #(2 * BT);

        send(0, 8'h3C, 1'b0, 1'b0, BT);
        #(2 * BT);

        e_brk[0]++;
        drive(0, 1'b0);
        #(12 * BT);
        check("break_wait_busy", busy_a, 1);
        check("break_pulses", n_brk[0], e_brk[0]);
        drive(0, 1'b1);
        #100;
        check("break_back_idle", busy_a, 0);
        #(2 * BT);

        set_ready_a(1'b0);
        send(0, 8'h11, 1'b0, 1'b1, BT);
        send(0, 8'h22, 1'b0, 1'b1, BT);
        #(BT);
        check("ovr_hold_data", data_a, 8'h11);
        check("ovr_hold_valid", valid_a, 1);
        check("ovr_pulses", n_ovr[0], e_ovr[0]);
        set_ready_a(1'b1);
        #100;
        check("ovr_drained", valid_a, 0);
        #(2 * BT);

        rst_pat = 8'hA5;
        drive(0, 1'b0);
        #(BT);
        for (int i = 0; i < 3; i++) begin
            drive(0, rst_pat[i]);
            #(BT);
        end
        drive(0, rst_pat[3]);
        #(BT / 2);
        check("midrst_busy_before", busy_a, 1);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy_a, 0);
        check("midrst_data", data_a, 0);
        check("midrst_valid", valid_a, 0);
        check("midrst_ferr", ferr_a, 0);
        drive(0, 1'b1);
        #100;
        rst = 1'b1;
        #(BT);
        send(0, 8'hC3, 1'b0, 1'b1, BT);
        #(2 * BT);

        sk_d = '{8'h00, 8'hFF, 8'h55, 8'h00, 8'hFF, 8'h55};
        sk_t = '{621, 621, 621, 659, 659, 659};
        for (int i = 0; i < 6; i++) begin
            send(0, sk_d[i], 1'b0, 1'b1, sk_t[i]);
            #(2 * BT);
        end

        for (int i = 0; i < 12; i++) begin
            da  = 8'($urandom);
            db  = 8'($urandom);
            pb  = 1'($urandom);
            sa  = ($urandom_range(0, 7) != 0);
            sb  = ($urandom_range(0, 7) != 0);
            bta = $urandom_range(621, 659);
            btb = $urandom_range(621, 659);
            fork
                send(0, da, 1'b0, sa, bta);
                send(1, db, pb, sb, btb);
            join
            #(2 * BT);
        end

        #(2 * BT);
        check("end_queue_a", qa.size(), 0);
        check("end_queue_b", qb.size(), 0);
        check("end_ovr_a", n_ovr[0], e_ovr[0]);
        check("end_ovr_b", n_ovr[1], e_ovr[1]);
        check("end_brk_a", n_brk[0], e_brk[0]);
        check("end_brk_b", n_brk[1], e_brk[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
